// File: rtl/stopwatch_button_conditioner.sv
`timescale 1ns/1ps
// Button front-end for the stopwatch: two-flop synchronisers, per-button debounce FSMs,
// a one-cycle active-low start_stop pulse per press and an active-low hold request.
//
// state      | meaning
// RELEASED   | debounced level 0, waiting for a pressed sample
// PRESS_PEND | counting consecutive pressed samples
// PRESSED    | debounced level 1, waiting for a released sample
// REL_PEND   | counting consecutive released samples
module stopwatch_button_conditioner #(
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned HOLD_TOGGLE    = 0
) (
    input  logic CLK_100Hz,
    input  logic reset_n,
    input  logic btn_start_stop_n,
    input  logic btn_hold_n,
    output logic start_stop,
    output logic hold,
    output logic start_stop_db,
    output logic hold_db
);
    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} state_t;

    localparam logic [3:0] TICKS = 4'(DEBOUNCE_TICKS);

    // Channel index 0 is start/stop, index 1 is hold.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    state_t     r_state     [2];
    state_t     w_state_nxt [2];
    logic [3:0] r_cnt       [2];
    logic [3:0] w_cnt_nxt   [2];
    logic [3:0] w_cnt_inc   [2];
    logic [1:0] w_level_nxt;
    logic [1:0] w_press;
    logic       r_start_stop;
    logic       r_hold;
    logic       r_start_stop_db;
    logic       r_hold_db;
    logic       r_toggle;

    always_ff @(posedge CLK_100Hz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
        end else begin
            r_sync1 <= {btn_hold_n, btn_start_stop_n};
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK_100Hz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= RELEASED;
                r_cnt[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 2'b00;
        w_level_nxt = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_cnt_inc[i] = (r_cnt[i] == 4'hF) ? r_cnt[i] : r_cnt[i] + 4'd1;
        end
        for (int i = 0; i < 2; i++) begin
            case (r_state[i])
                RELEASED: begin
                    if (!r_sync2[i]) begin
                        w_cnt_nxt[i] = 4'd1;
                        if (TICKS <= 4'd1) begin
                            w_state_nxt[i] = PRESSED;
                            w_press[i]     = 1'b1;
                        end else begin
                            w_state_nxt[i] = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (r_sync2[i]) begin
                        w_state_nxt[i] = RELEASED;
                        w_cnt_nxt[i]   = 4'd0;
                    end else begin
                        w_cnt_nxt[i] = w_cnt_inc[i];
                        if (w_cnt_inc[i] >= TICKS) begin
                            w_state_nxt[i] = PRESSED;
                            w_press[i]     = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (r_sync2[i]) begin
                        w_cnt_nxt[i] = 4'd1;
                        if (TICKS <= 4'd1) begin
                            w_state_nxt[i] = RELEASED;
                        end else begin
                            w_state_nxt[i] = REL_PEND;
                        end
                    end
                end
                REL_PEND: begin
                    // A pressed sample here is release bounce: no new press event.
                    if (!r_sync2[i]) begin
                        w_state_nxt[i] = PRESSED;
                        w_cnt_nxt[i]   = 4'd0;
                    end else begin
                        w_cnt_nxt[i] = w_cnt_inc[i];
                        if (w_cnt_inc[i] >= TICKS) begin
                            w_state_nxt[i] = RELEASED;
                            w_cnt_nxt[i]   = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = RELEASED;
                    w_cnt_nxt[i]   = 4'd0;
                end
            endcase
            w_level_nxt[i] = (w_state_nxt[i] == PRESSED) || (w_state_nxt[i] == REL_PEND);
        end
    end

    always_ff @(posedge CLK_100Hz or negedge reset_n) begin
        if (!reset_n) begin
            r_start_stop    <= 1'b1;
            r_hold          <= 1'b1;
            r_start_stop_db <= 1'b0;
            r_hold_db       <= 1'b0;
            r_toggle        <= 1'b0;
        end else begin
            r_start_stop    <= ~w_press[0];
            r_start_stop_db <= w_level_nxt[0];
            r_hold_db       <= w_level_nxt[1];
            if (w_press[1]) begin
                r_toggle <= ~r_toggle;
            end
            r_hold <= (HOLD_TOGGLE != 0) ? ~(r_toggle ^ w_press[1]) : ~w_level_nxt[1];
        end
    end

    assign start_stop    = r_start_stop;
    assign hold          = r_hold;
    assign start_stop_db = r_start_stop_db;
    assign hold_db       = r_hold_db;

endmodule

// File: tb/tb_stopwatch_button_conditioner.sv
`timescale 1ns/1ps
// Bench for stopwatch_button_conditioner: directed latency/bounce/reset cases plus random
// button traffic, checked every cycle against a run-length model of the debounce rules.
module tb_stopwatch_button_conditioner;
    localparam int D = 3;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic btn_ss_n   = 1'b1;
    logic btn_hold_n = 1'b1;
    logic ss0, hold0, ssdb0, holddb0;
    logic ss1, hold1, ssdb1, holddb1;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    int pulse_cnt = 0;
    int last_pulse_edge = -1;

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    stopwatch_button_conditioner #(.DEBOUNCE_TICKS(D), .HOLD_TOGGLE(0)) dut0 (
        .CLK_100Hz(clk), .reset_n(reset_n),
        .btn_start_stop_n(btn_ss_n), .btn_hold_n(btn_hold_n),
        .start_stop(ss0), .hold(hold0), .start_stop_db(ssdb0), .hold_db(holddb0)
    );

    stopwatch_button_conditioner #(.DEBOUNCE_TICKS(D), .HOLD_TOGGLE(1)) dut1 (
        .CLK_100Hz(clk), .reset_n(reset_n),
        .btn_start_stop_n(btn_ss_n), .btn_hold_n(btn_hold_n),
        .start_stop(ss1), .hold(hold1), .start_stop_db(ssdb1), .hold_db(holddb1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_no, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ss0", ss0, 1'b1);     chk("rst_hold0", hold0, 1'b1);
        chk("rst_ssdb0", ssdb0, 1'b0); chk("rst_holddb0", holddb0, 1'b0);
        chk("rst_ss1", ss1, 1'b1);     chk("rst_hold1", hold1, 1'b1);
        chk("rst_ssdb1", ssdb1, 1'b0); chk("rst_holddb1", holddb1, 1'b0);
    endtask

    task automatic wait_edge(input int n);
        while (edge_no < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a raw sample reaches the debouncer two edges later; the debounced level flips
    // once D consecutive samples disagree with it, and a press event is a 0->1 flip.
    bit m_q0[$] = '{1'b1, 1'b1};
    bit m_q1[$] = '{1'b1, 1'b1};
    int m_run0 = 0, m_run1 = 0;
    bit m_lvl0 = 0, m_lvl1 = 0;
    bit m_prs0 = 0, m_prs1 = 0;
    bit m_latch = 0;

    function automatic void step_ch(input bit seen, inout int run, inout bit lvl, output bit prs);
        prs = 1'b0;
        if ((!seen) != lvl) begin
            run++;
            if (run >= D) begin
                lvl = !seen;
                run = 0;
                prs = lvl;
            end
        end else begin
            run = 0;
        end
    endfunction

    initial forever begin
        bit seen0, seen1;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_q0 = '{1'b1, 1'b1};
            m_q1 = '{1'b1, 1'b1};
            m_run0 = 0; m_run1 = 0;
            m_lvl0 = 0; m_lvl1 = 0;
            m_prs0 = 0; m_prs1 = 0;
            m_latch = 0;
        end else begin
            seen0 = m_q0.pop_front();
            m_q0.push_back(btn_ss_n);
            seen1 = m_q1.pop_front();
            m_q1.push_back(btn_hold_n);
            step_ch(seen0, m_run0, m_lvl0, m_prs0);
            step_ch(seen1, m_run1, m_lvl1, m_prs1);
            if (m_prs1) m_latch = !m_latch;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n === 1'b1) begin
            chk("cyc_ss0", ss0, !m_prs0);
            chk("cyc_ss1", ss1, !m_prs0);
            chk("cyc_ssdb0", ssdb0, m_lvl0);
            chk("cyc_ssdb1", ssdb1, m_lvl0);
            chk("cyc_holddb0", holddb0, m_lvl1);
            chk("cyc_holddb1", holddb1, m_lvl1);
            chk("cyc_hold0", hold0, !m_lvl1);
            chk("cyc_hold1", hold1, !m_latch);
            if (ss0 === 1'b0) begin
                pulse_cnt++;
                last_pulse_edge = edge_no;
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: time limit reached at edge %0d, expected end of test", edge_no);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r, p0;
        int len_ss, len_hd;
        logic bseq [7];
        bseq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press held 50 cycles.
        @(negedge clk); p0 = pulse_cnt; btn_ss_n = 1'b0; e0 = edge_no + 1;
        wait_edge(e0 + 3); chk("clean_ss_e3", ss0, 1'b1); chk("clean_db_e3", ssdb0, 1'b0);
        wait_edge(e0 + 4); chk("clean_ss_e4", ss0, 1'b0); chk("clean_db_e4", ssdb0, 1'b1);
        wait_edge(e0 + 5); chk("clean_ss_e5", ss0, 1'b1); chk("clean_db_e5", ssdb0, 1'b1);
        wait_edge(e0 + 50);
        chk_int("clean_pulses", pulse_cnt - p0, 1);
        chk_int("clean_pulse_edge", last_pulse_edge, e0 + 4);
        @(negedge clk); btn_ss_n = 1'b1;
        repeat (8) @(negedge clk);

        // Press bounce 1,0,1,0,0,0,0: stable run starts at index 3.
        p0 = pulse_cnt; e0 = edge_no + 1;
        for (int i = 0; i < 7; i++) begin
            btn_ss_n = bseq[i];
            if (i < 6) @(negedge clk);
        end
        wait_edge(e0 + 14);
        chk_int("bounce_pulses", pulse_cnt - p0, 1);
        chk_int("bounce_pulse_edge", last_pulse_edge, e0 + 7);
        @(negedge clk); btn_ss_n = 1'b1;
        repeat (8) @(negedge clk);

        // Two-cycle glitch is rejected.
        p0 = pulse_cnt; btn_ss_n = 1'b0; e0 = edge_no + 1;
        @(negedge clk);
        @(negedge clk); btn_ss_n = 1'b1;
        wait_edge(e0 + 3); chk("glitch_db_e3", ssdb0, 1'b0);
        wait_edge(e0 + 10);
        chk_int("glitch_pulses", pulse_cnt - p0, 0);
        chk("glitch_db_end", ssdb0, 1'b0);

        // Hold press 20 cycles, release with one bounce.
        @(negedge clk); btn_hold_n = 1'b0; e0 = edge_no + 1;
        wait_edge(e0 + 3);
        chk("hold_e3_h0", hold0, 1'b1); chk("hold_e3_db0", holddb0, 1'b0); chk("hold_e3_h1", hold1, 1'b1);
        wait_edge(e0 + 4);
        chk("hold_e4_h0", hold0, 1'b0); chk("hold_e4_db0", holddb0, 1'b1); chk("hold_e4_h1", hold1, 1'b0);
        wait_edge(e0 + 19);
        @(negedge clk); btn_hold_n = 1'b1; r = edge_no + 1;
        @(negedge clk); btn_hold_n = 1'b0;
        @(negedge clk); btn_hold_n = 1'b1;
        wait_edge(r + 5); chk("hrel_r5_h0", hold0, 1'b0); chk("hrel_r5_h1", hold1, 1'b0);
        wait_edge(r + 6); chk("hrel_r6_h0", hold0, 1'b1); chk("hrel_r6_db0", holddb0, 1'b0);
        chk("hrel_r6_h1", hold1, 1'b0);
        repeat (6) @(negedge clk);

        // Second clean hold press toggles the latch back; clean release latency.
        btn_hold_n = 1'b0; e0 = edge_no + 1;
        wait_edge(e0 + 3); chk("hold2_e3_h1", hold1, 1'b0);
        wait_edge(e0 + 4); chk("hold2_e4_h1", hold1, 1'b1); chk("hold2_e4_h0", hold0, 1'b0);
        wait_edge(e0 + 9);
        @(negedge clk); btn_hold_n = 1'b1; r = edge_no + 1;
        wait_edge(r + 3); chk("hrel2_r3_h0", hold0, 1'b0); chk("hrel2_r3_db0", holddb0, 1'b1);
        wait_edge(r + 4); chk("hrel2_r4_h0", hold0, 1'b1); chk("hrel2_r4_db0", holddb0, 1'b0);
        chk("hrel2_r4_h1", hold1, 1'b1);
        repeat (6) @(negedge clk);

        // Both buttons on the same edge.
        btn_ss_n = 1'b0; btn_hold_n = 1'b0; e0 = edge_no + 1;
        wait_edge(e0 + 3); chk("both_e3_ss0", ss0, 1'b1); chk("both_e3_h0", hold0, 1'b1);
        wait_edge(e0 + 4);
        chk("both_e4_ss0", ss0, 1'b0); chk("both_e4_h0", hold0, 1'b0);
        chk("both_e4_ss1", ss1, 1'b0); chk("both_e4_h1", hold1, 1'b0);
        wait_edge(e0 + 8);
        @(negedge clk); btn_ss_n = 1'b1; btn_hold_n = 1'b1;
        repeat (8) @(negedge clk);

        // Reset during the pulse cycle, button still held at release.
        btn_ss_n = 1'b0; e0 = edge_no + 1;
        wait_edge(e0 + 4); chk("rstp_pulse", ss0, 1'b0);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        @(negedge clk); p0 = pulse_cnt; reset_n = 1'b1; r = edge_no + 1;
        wait_edge(r + 3); chk("rstr_r3_ss0", ss0, 1'b1);
        wait_edge(r + 4); chk("rstr_r4_ss0", ss0, 1'b0);
        wait_edge(r + 12);
        chk_int("rstr_pulses", pulse_cnt - p0, 1);
        @(negedge clk); btn_ss_n = 1'b1;
        repeat (8) @(negedge clk);

        // Random button traffic with occasional resets.
        len_ss = 0; len_hd = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (reset_n == 1'b0) reset_n = 1'b1;
            else if ($urandom_range(0, 99) == 0) reset_n = 1'b0;
            if (len_ss == 0) begin
                btn_ss_n = 1'($urandom_range(0, 1));
                len_ss = $urandom_range(1, 7);
            end
            if (len_hd == 0) begin
                btn_hold_n = 1'($urandom_range(0, 1));
                len_hd = $urandom_range(1, 7);
            end
            len_ss--;
            len_hd--;
        end
        @(negedge clk); reset_n = 1'b1; btn_ss_n = 1'b1; btn_hold_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
